// File: rtl/pipe_adder_pkg.sv
// Shared constants and helpers for the segmented pipelined adder/subtractor.
// Covers the default geometry, stage-count derivation, configuration check and flag math.
package pipe_adder_pkg;

    localparam int unsigned DEF_W   = 32;
    localparam int unsigned DEF_SEG = 8;

    function automatic int unsigned calc_nseg(input int unsigned w, input int unsigned seg);
        return (seg == 0) ? 0 : w / seg;
    endfunction

    // The segment must be non-empty, no wider than the operand, and divide it exactly.
    function automatic bit seg_cfg_ok(input int unsigned w, input int unsigned seg);
        return (seg >= 1) && (seg <= w) && ((w % seg) == 0);
    endfunction

    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/pipe_adder_stage.sv
// One elastic pipeline stage: adds a single SEG-bit segment with the incoming carry,
// shifts the pending operand bits down and appends the new bits to the lower result.
module pipe_adder_stage
    import pipe_adder_pkg::*;
#(
    parameter int unsigned SEG  = 8,
    parameter int unsigned LO_W = 0,
    parameter int unsigned HI_W = 24
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        up_vld,
    output logic                        up_rdy,
    output logic                        dn_vld,
    input  logic                        dn_rdy,
    input  logic                        carry_in,
    input  logic [1:0]                  sgn_in,
    input  logic [SEG+LO_W+HI_W-1:0]    a_in,
    input  logic [SEG+LO_W+HI_W-1:0]    b_in,
    input  logic [SEG+LO_W+HI_W-1:0]    lo_in,
    output logic                        carry_out,
    output logic [1:0]                  sgn_out,
    output logic [SEG+LO_W+HI_W-1:0]    a_out,
    output logic [SEG+LO_W+HI_W-1:0]    b_out,
    output logic [SEG+LO_W+HI_W-1:0]    lo_out
);

    localparam int unsigned W = SEG + LO_W + HI_W;
    localparam logic [W-1:0] ONES    = '1;
    localparam logic [W-1:0] HI_MASK = ONES >> (W - HI_W);
    localparam logic [W-1:0] LO_MASK = ONES >> (W - LO_W);

    logic           vld_reg;
    logic           carry_reg;
    logic [1:0]     sgn_reg;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [W-1:0]   lo_reg;

    logic [SEG:0]   seg_sum;
    logic [W-1:0]   a_next;
    logic [W-1:0]   b_next;
    logic [W-1:0]   lo_next;
    logic           rdy;

    assign seg_sum = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]} + {{SEG{1'b0}}, carry_in};

    // Operand buses stay right-aligned: the next stage always adds bits [SEG-1:0].
    assign a_next  = (a_in >> SEG) & HI_MASK;
    assign b_next  = (b_in >> SEG) & HI_MASK;
    assign lo_next = (lo_in & LO_MASK) | (W'(seg_sum[SEG-1:0]) << LO_W);

    assign rdy    = !vld_reg || dn_rdy;
    assign up_rdy = rdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_reg   <= 1'b0;
            carry_reg <= 1'b0;
            sgn_reg   <= 2'b00;
            a_reg     <= '0;
            b_reg     <= '0;
            lo_reg    <= '0;
        end else if (flush) begin
            vld_reg <= 1'b0;
        end else if (rdy) begin
            vld_reg <= up_vld;
            if (up_vld) begin
                carry_reg <= seg_sum[SEG];
                sgn_reg   <= sgn_in;
                a_reg     <= a_next;
                b_reg     <= b_next;
                lo_reg    <= lo_next;
            end
        end
    end

    assign dn_vld    = vld_reg;
    assign carry_out = carry_reg;
    assign sgn_out   = sgn_reg;
    assign a_out     = a_reg;
    assign b_out     = b_reg;
    assign lo_out    = lo_reg;

endmodule

// File: rtl/pipe_adder_p.sv
// Segmented pipelined adder/subtractor with per-stage valid/ready backpressure.
// NSEG stages each add one segment; carry, pending operands and signs ride along.
module pipe_adder_p
    import pipe_adder_pkg::*;
#(
    parameter int unsigned W   = DEF_W,
    parameter int unsigned SEG = DEF_SEG
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_vld,
    output logic            in_rdy,
    input  logic            sub,
    input  logic [W-1:0]    x_0,
    input  logic [W-1:0]    x_1,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic [W-1:0]    result,
    output logic            c_out,
    output logic            ovf
);

    localparam int unsigned NSEG = calc_nseg(W, SEG);

    generate
        if (!seg_cfg_ok(W, SEG)) begin : g_bad_cfg
            $error("pipe_adder_p: W must be a nonzero multiple of SEG");
        end
    endgenerate

    logic           vld_bus   [0:NSEG];
    logic           rdy_bus   [0:NSEG];
    logic           carry_bus [0:NSEG];
    logic [1:0]     sgn_bus   [0:NSEG];
    logic [W-1:0]   a_bus     [0:NSEG];
    logic [W-1:0]   b_bus     [0:NSEG];
    logic [W-1:0]   lo_bus    [0:NSEG];
    logic [W-1:0]   b_prime;
    logic           unused_tail;

    // Subtraction is A + ~B + 1: invert B and seed the carry chain with sub.
    assign b_prime      = sub ? ~x_1 : x_1;
    assign vld_bus[0]   = in_vld;
    assign carry_bus[0] = sub;
    assign sgn_bus[0]   = {x_0[W-1], b_prime[W-1]};
    assign a_bus[0]     = x_0;
    assign b_bus[0]     = b_prime;
    assign lo_bus[0]    = '0;
    assign rdy_bus[NSEG] = out_rdy;
    assign in_rdy       = rdy_bus[0];

    generate
        for (genvar gi = 0; gi < NSEG; gi++) begin : g_stage
            pipe_adder_stage #(
                .SEG  (SEG),
                .LO_W (gi * SEG),
                .HI_W (W - (gi + 1) * SEG)
            ) u_stage (
                .clk       (clk),
                .reset     (reset),
                .flush     (flush),
                .up_vld    (vld_bus[gi]),
                .up_rdy    (rdy_bus[gi]),
                .dn_vld    (vld_bus[gi+1]),
                .dn_rdy    (rdy_bus[gi+1]),
                .carry_in  (carry_bus[gi]),
                .sgn_in    (sgn_bus[gi]),
                .a_in      (a_bus[gi]),
                .b_in      (b_bus[gi]),
                .lo_in     (lo_bus[gi]),
                .carry_out (carry_bus[gi+1]),
                .sgn_out   (sgn_bus[gi+1]),
                .a_out     (a_bus[gi+1]),
                .b_out     (b_bus[gi+1]),
                .lo_out    (lo_bus[gi+1])
            );
        end
    endgenerate

    // The last stage has no pending operand bits; its buses are always zero.
    assign unused_tail = ^{a_bus[NSEG], b_bus[NSEG]};

    assign out_vld = vld_bus[NSEG];
    assign result  = lo_bus[NSEG];
    assign c_out   = carry_bus[NSEG];
    assign ovf     = signed_ovf(sgn_bus[NSEG][1], sgn_bus[NSEG][0], lo_bus[NSEG][W-1]);

endmodule

// File: tb/tb_pipe_adder_p.sv
// Directed bench for pipe_adder_p at 32/8, 16/16 and 64/4 geometries.
// Expected results are hand-computed; a negedge monitor collects 32-bit transfers in order.
module tb_pipe_adder_p;

    logic clk = 1'b0;
    logic reset;

    logic        flush_a, in_vld_a, in_rdy_a, sub_a, out_vld_a, out_rdy_a, c_a, o_a;
    logic [31:0] x0_a, x1_a, res_a;
    logic        flush_b, in_vld_b, in_rdy_b, sub_b, out_vld_b, out_rdy_b, c_b, o_b;
    logic [15:0] x0_b, x1_b, res_b;
    logic        flush_c, in_vld_c, in_rdy_c, sub_c, out_vld_c, out_rdy_c, c_c, o_c;
    logic [63:0] x0_c, x1_c, res_c;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    logic [33:0] got_q[$];
    int          got_cyc[$];

    logic [31:0] va   [8];
    logic [31:0] vb   [8];
    logic [33:0] vexp [8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipe_adder_p #(.W(32), .SEG(8)) dut_a (
        .clk(clk), .reset(reset), .flush(flush_a), .in_vld(in_vld_a), .in_rdy(in_rdy_a),
        .sub(sub_a), .x_0(x0_a), .x_1(x1_a), .out_vld(out_vld_a), .out_rdy(out_rdy_a),
        .result(res_a), .c_out(c_a), .ovf(o_a)
    );
    pipe_adder_p #(.W(16), .SEG(16)) dut_b (
        .clk(clk), .reset(reset), .flush(flush_b), .in_vld(in_vld_b), .in_rdy(in_rdy_b),
        .sub(sub_b), .x_0(x0_b), .x_1(x1_b), .out_vld(out_vld_b), .out_rdy(out_rdy_b),
        .result(res_b), .c_out(c_b), .ovf(o_b)
    );
    pipe_adder_p #(.W(64), .SEG(4)) dut_c (
        .clk(clk), .reset(reset), .flush(flush_c), .in_vld(in_vld_c), .in_rdy(in_rdy_c),
        .sub(sub_c), .x_0(x0_c), .x_1(x1_c), .out_vld(out_vld_c), .out_rdy(out_rdy_c),
        .result(res_c), .c_out(c_c), .ovf(o_c)
    );

    always @(negedge clk) begin
        if (!reset && out_vld_a && out_rdy_a) begin
            got_q.push_back({res_a, c_a, o_a});
            got_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check32(input string tag, input logic [33:0] want);
        logic [33:0] v;
        check({tag, "_present"}, 64'(got_q.size() != 0), 64'd1);
        if (got_q.size() != 0) begin
            v = got_q.pop_front();
            check(tag, v, want);
        end
    endtask

    task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic s);
        int guard;
        guard = 0;
        x0_a = a; x1_a = b; sub_a = s; in_vld_a = 1'b1;
        #1;
        while (!in_rdy_a && guard < 50) begin
            tick();
            guard++;
        end
        check("send32_in_rdy", in_rdy_a, 1'b1);
        tick();
        in_vld_a = 1'b0;
    endtask

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic s);
        x0_b = a; x1_b = b; sub_b = s; in_vld_b = 1'b1;
        #1;
        check("send16_in_rdy", in_rdy_b, 1'b1);
        tick();
        in_vld_b = 1'b0;
    endtask

    task automatic send64(input logic [63:0] a, input logic [63:0] b, input logic s);
        x0_c = a; x1_c = b; sub_c = s; in_vld_c = 1'b1;
        #1;
        check("send64_in_rdy", in_rdy_c, 1'b1);
        tick();
        in_vld_c = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        va[0] = 32'h0000_0001; vb[0] = 32'h0000_0002; vexp[0] = {32'h0000_0003, 1'b0, 1'b0};
        va[1] = 32'hFFFF_FFFF; vb[1] = 32'h0000_0001; vexp[1] = {32'h0000_0000, 1'b1, 1'b0};
        va[2] = 32'h7FFF_FFFF; vb[2] = 32'h0000_0001; vexp[2] = {32'h8000_0000, 1'b0, 1'b1};
        va[3] = 32'h8000_0000; vb[3] = 32'h8000_0000; vexp[3] = {32'h0000_0000, 1'b1, 1'b1};
        va[4] = 32'h1234_5678; vb[4] = 32'h1111_1111; vexp[4] = {32'h2345_6789, 1'b0, 1'b0};
        va[5] = 32'h0000_00FF; vb[5] = 32'h0000_0001; vexp[5] = {32'h0000_0100, 1'b0, 1'b0};
        va[6] = 32'h0000_FFFF; vb[6] = 32'h0000_0001; vexp[6] = {32'h0001_0000, 1'b0, 1'b0};
        va[7] = 32'hFFFF_FFFF; vb[7] = 32'hFFFF_FFFF; vexp[7] = {32'hFFFF_FFFE, 1'b1, 1'b0};

        reset = 1'b1;
        flush_a = 0; in_vld_a = 0; sub_a = 0; x0_a = '0; x1_a = '0; out_rdy_a = 1;
        flush_b = 0; in_vld_b = 0; sub_b = 0; x0_b = '0; x1_b = '0; out_rdy_b = 1;
        flush_c = 0; in_vld_c = 0; sub_c = 0; x0_c = '0; x1_c = '0; out_rdy_c = 1;

        // Reset state
        tick();
        check("rst_out_vld", out_vld_a, 1'b0);
        check("rst_result", res_a, 32'h0);
        check("rst_c_out", c_a, 1'b0);
        check("rst_ovf", o_a, 1'b0);
        reset = 1'b0;
        #1;
        check("rst_in_rdy", in_rdy_a, 1'b1);

        // Single add: latency of four edges, one-cycle valid
        send32(32'h00FF_FFFF, 32'h0000_0001, 1'b0);
        check("lat_e0", out_vld_a, 1'b0);
        tick();
        check("lat_e1", out_vld_a, 1'b0);
        tick();
        check("lat_e2", out_vld_a, 1'b0);
        tick();
        check("lat_e3_vld", out_vld_a, 1'b1);
        check("single_add", {res_a, c_a, o_a}, {32'h0100_0000, 1'b0, 1'b0});
        tick();
        check("single_vld_drop", out_vld_a, 1'b0);
        got_q.delete();
        got_cyc.delete();

        // Subtraction: borrow, then signed overflow
        send32(32'h0000_0000, 32'h0000_0001, 1'b1);
        send32(32'h8000_0000, 32'h0000_0001, 1'b1);
        repeat (5) tick();
        pop_check32("sub_borrow", {32'hFFFF_FFFF, 1'b0, 1'b0});
        pop_check32("sub_ovf", {32'h7FFF_FFFF, 1'b1, 1'b1});
        got_cyc.delete();

        // Back-to-back stream of 8
        for (int i = 0; i < 8; i++) send32(va[i], vb[i], 1'b0);
        repeat (6) tick();
        check("stream_count", got_q.size(), 8);
        if (got_cyc.size() == 8) check("stream_consecutive", got_cyc[7] - got_cyc[0], 7);
        for (int i = 0; i < 8; i++) pop_check32($sformatf("stream_%0d", i), vexp[i]);
        got_q.delete();
        got_cyc.delete();

        // Backpressure: fill four deep, hold, then drain
        out_rdy_a = 1'b0;
        for (int i = 0; i < 4; i++) send32(va[i], vb[i], 1'b0);
        x0_a = va[4]; x1_a = vb[4]; sub_a = 1'b0; in_vld_a = 1'b1;
        #1;
        check("bp_in_rdy_full", in_rdy_a, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check("bp_out_vld_held", out_vld_a, 1'b1);
            check("bp_result_held", {res_a, c_a, o_a}, vexp[0]);
            tick();
        end
        out_rdy_a = 1'b1;
        for (int i = 4; i < 8; i++) send32(va[i], vb[i], 1'b0);
        repeat (6) tick();
        check("bp_count", got_q.size(), 8);
        for (int i = 0; i < 8; i++) pop_check32($sformatf("bp_%0d", i), vexp[i]);
        got_q.delete();

        // Flush with three in flight plus a same-cycle input
        for (int i = 0; i < 3; i++) send32(va[i], vb[i], 1'b0);
        flush_a = 1'b1; x0_a = va[3]; x1_a = vb[3]; in_vld_a = 1'b1;
        #1;
        tick();
        flush_a = 1'b0; in_vld_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("flush_vld_%0d", k), out_vld_a, 1'b0);
            tick();
        end
        check("flush_nothing_out", got_q.size(), 0);
        send32(32'h0000_0005, 32'h0000_0003, 1'b0);
        repeat (5) tick();
        pop_check32("post_flush", {32'h0000_0008, 1'b0, 1'b0});

        // W=16, SEG=16: single-register adder
        send16(16'h7FFF, 16'h0001, 1'b0);
        check("w16_vld0", out_vld_b, 1'b1);
        check("w16_add_ovf", {res_b, c_b, o_b}, {16'h8000, 1'b0, 1'b1});
        send16(16'h0003, 16'h0005, 1'b1);
        check("w16_vld1", out_vld_b, 1'b1);
        check("w16_sub_neg", {res_b, c_b, o_b}, {16'hFFFE, 1'b0, 1'b0});
        send16(16'h8000, 16'h0001, 1'b1);
        check("w16_sub_ovf", {res_b, c_b, o_b}, {16'h7FFF, 1'b1, 1'b1});
        send16(16'hFFFF, 16'hFFFF, 1'b0);
        check("w16_add_carry", {res_b, c_b, o_b}, {16'hFFFE, 1'b1, 1'b0});
        tick();
        check("w16_vld_drop", out_vld_b, 1'b0);

        // W=64, SEG=4: sixteen stages, full carry ripple
        send64(64'h0FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        lat = 0;
        while (!out_vld_c && lat < 40) begin
            tick();
            lat++;
        end
        check("w64_latency", lat, 15);
        check("w64_ripple", {res_c, c_c, o_c}, {64'h1000_0000_0000_0000, 1'b0, 1'b0});
        tick();
        send64(64'h0, 64'h1, 1'b1);
        send64(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        send64(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
        repeat (13) tick();
        check("w64_sub_borrow", {out_vld_c, res_c, c_c, o_c}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0});
        tick();
        check("w64_add_ovf", {out_vld_c, res_c, c_c, o_c}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1});

        // Async reset mid-stream: outputs drop without a clock edge
        #2;
        reset = 1'b1;
        #1;
        check("arst_vld64", out_vld_c, 1'b0);
        check("arst_res64", res_c, 64'h0);
        #2;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("arst_lost_%0d", k), out_vld_c, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
